// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 register/icode constants shared by the scoreboard
package y86_pkg;

    localparam logic [3:0] RNONE = 4'hF;
    localparam int         NREG  = 15;

    localparam logic [3:0] RRAX = 4'h0;
    localparam logic [3:0] RRCX = 4'h1;
    localparam logic [3:0] RRDX = 4'h2;
    localparam logic [3:0] RRBX = 4'h3;
    localparam logic [3:0] RSP  = 4'h4;
    localparam logic [3:0] RBP  = 4'h5;

    localparam logic [3:0] CMOVXX = 4'h2;
    localparam logic [3:0] IRMOVQ = 4'h3;
    localparam logic [3:0] MRMOVQ = 4'h5;
    localparam logic [3:0] OPQ    = 4'h6;
    localparam logic [3:0] CALL   = 4'h8;
    localparam logic [3:0] RET    = 4'h9;
    localparam logic [3:0] PUSHQ  = 4'hA;
    localparam logic [3:0] POPQ   = 4'hB;

    // Number of the two destination fields naming idx (0, 1 or 2); RNONE never matches.
    function automatic logic [1:0] match2(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] idx);
        logic [1:0] n;
        n = {1'b0, (a == idx)} + {1'b0, (b == idx)};
        return (idx == RNONE) ? 2'd0 : n;
    endfunction

endpackage

// File: rtl/y86_reg_scoreboard_if.sv
// rtl/y86_reg_scoreboard_if.sv - decode/writeback/squash bundle for the register scoreboard
interface y86_reg_scoreboard_if;
    import y86_pkg::*;

    logic        issue_valid;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic        wb_valid;
    logic [3:0]  W_dstE;
    logic [3:0]  W_dstM;
    logic        kill_valid;
    logic [3:0]  kill_dstE;
    logic [3:0]  kill_dstM;
    logic        clear;
    logic        stall;
    logic [NREG-1:0] busy_mask;
    logic        err_ovf;
    logic        err_unf;

    modport master (
        output issue_valid, d_srcA, d_srcB, d_dstE, d_dstM,
        output wb_valid, W_dstE, W_dstM,
        output kill_valid, kill_dstE, kill_dstM, clear,
        input  stall, busy_mask, err_ovf, err_unf
    );

    modport slave (
        input  issue_valid, d_srcA, d_srcB, d_dstE, d_dstM,
        input  wb_valid, W_dstE, W_dstM,
        input  kill_valid, kill_dstE, kill_dstM, clear,
        output stall, busy_mask, err_ovf, err_unf
    );

endinterface

// File: rtl/sb_counter.sv
// rtl/sb_counter.sv - one saturating pending-write counter with over/underflow detect
module sb_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       inc,
    input  logic [1:0]       dec_a,
    input  logic [1:0]       dec_b,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             ovf,
    output logic             unf
);
    localparam int SW = CNT_W + 2;
    localparam logic signed [SW-1:0] MAXV = SW'((1 << CNT_W) - 1);

    logic [CNT_W-1:0]     r_cnt;
    logic                 r_nz;
    logic signed [SW-1:0] w_sum;
    logic [CNT_W-1:0]     w_next;

    // Net change is applied in one step so same-cycle issue and retire cancel.
    always_comb begin
        w_sum  = signed'(SW'(r_cnt)) + signed'(SW'(inc))
               - signed'(SW'(dec_a)) - signed'(SW'(dec_b));
        w_next = r_cnt;
        ovf    = 1'b0;
        unf    = 1'b0;
        if (clr) begin
            w_next = '0;
        end else if (w_sum[SW-1]) begin
            w_next = '0;
            unf    = 1'b1;
        end else if (w_sum > MAXV) begin
            w_next = '1;
            ovf    = 1'b1;
        end else begin
            w_next = w_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_nz  <= 1'b0;
        end else begin
            r_cnt <= w_next;
            r_nz  <= (w_next != '0);
        end
    end

    assign cnt = r_cnt;
    assign nz  = r_nz;

endmodule

// File: rtl/y86_reg_scoreboard.sv
// rtl/y86_reg_scoreboard.sv - per-register pending-write scoreboard raising decode RAW stalls
module y86_reg_scoreboard
    import y86_pkg::*;
#(
    parameter int CNT_W     = 3,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    y86_reg_scoreboard_if.slave  bus
);
    logic [NREG-1:0] w_nz;
    logic [NREG-1:0] w_ovf;
    logic [NREG-1:0] w_unf;
    logic [NREG-1:0] w_src_hit;
    logic [NREG-1:0] w_bypass;
    logic            w_stall;
    logic            w_accept;
    logic            r_err_ovf;
    logic            r_err_unf;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        localparam logic [3:0] IDX = 4'(g);
        logic [1:0]       w_inc;
        logic [1:0]       w_dwb;
        logic [1:0]       w_dkill;
        logic [CNT_W-1:0] w_cnt;

        assign w_inc   = w_accept      ? match2(bus.d_dstE, bus.d_dstM, IDX)       : 2'd0;
        assign w_dwb   = bus.wb_valid   ? match2(bus.W_dstE, bus.W_dstM, IDX)       : 2'd0;
        assign w_dkill = bus.kill_valid ? match2(bus.kill_dstE, bus.kill_dstM, IDX) : 2'd0;

        assign w_src_hit[g] = (bus.d_srcA == IDX) || (bus.d_srcB == IDX);
        // A retiring writeback covering every outstanding write resolves the hazard now.
        assign w_bypass[g]  = WB_BYPASS && bus.wb_valid && (w_dkill == 2'd0)
                           && (w_cnt == CNT_W'(w_dwb));

        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (w_inc),
            .dec_a (w_dwb),
            .dec_b (w_dkill),
            .clr   (bus.clear),
            .cnt   (w_cnt),
            .nz    (w_nz[g]),
            .ovf   (w_ovf[g]),
            .unf   (w_unf[g])
        );
    end

    assign w_stall  = bus.issue_valid && !bus.clear && |(w_src_hit & w_nz & ~w_bypass);
    assign w_accept = bus.issue_valid && !w_stall && !bus.clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_err_ovf <= r_err_ovf | (|w_ovf);
            r_err_unf <= r_err_unf | (|w_unf);
        end
    end

    assign bus.stall     = w_stall;
    assign bus.busy_mask = w_nz;
    assign bus.err_ovf   = r_err_ovf;
    assign bus.err_unf   = r_err_unf;

endmodule
